// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out shift register with a
// valid/ready load side and a stallable serial side (shift_en).
// A loaded word is presented one bit per consumed edge, MSB or LSB first,
// and a one-cycle done pulse marks the return to IDLE after the last bit.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               done_q,  done_d;

  // One-position shift toward the output end, vacated bit filled with 0.
  logic [WIDTH-1:0]   shreg_shifted;

  // Direction of the shift follows the transmit order.
  always_comb begin
    shreg_shifted = '0;
    if (MSB_FIRST != 0) begin
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // State, shift register, bit counter and done flag; reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load in IDLE, shift or stall in SHIFT, finish on last bit.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // shift_en has no effect here; only a load moves the FSM.
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // load_valid is ignored so the word in flight is never disturbed.
        if (shift_en) begin
          if (cnt_q == LAST_CNT) begin
            // Last bit consumed: drop the leftovers so IDLE starts clean.
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        // shift_en low: everything holds, stall may last indefinitely.
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so they are glitch-free per cycle.
  always_comb begin
    load_ready = 1'b0;
    sout_valid = 1'b0;
    sout       = 1'b0;
    if (state_q == SHIFT) begin
      sout_valid = 1'b1;
      sout       = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    end else begin
      load_ready = 1'b1;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share
// all stimulus; directed vectors with hand-written expected bit streams.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         shift_en;

  logic load_ready_m, sout_m, sout_valid_m, done_m;
  logic load_ready_l, sout_l, sout_valid_l, done_l;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready_m),
    .shift_en   (shift_en),
    .sout       (sout_m),
    .sout_valid (sout_valid_m),
    .done       (done_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready_l),
    .shift_en   (shift_en),
    .sout       (sout_l),
    .sout_valid (sout_valid_l),
    .done       (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_rdy_m"}, load_ready_m, 1'b1);
    chk({tag, "_vld_m"}, sout_valid_m, 1'b0);
    chk({tag, "_sout_m"}, sout_m, 1'b0);
    chk({tag, "_done_m"}, done_m, exp_done);
    chk({tag, "_rdy_l"}, load_ready_l, 1'b1);
    chk({tag, "_vld_l"}, sout_valid_l, 1'b0);
    chk({tag, "_sout_l"}, sout_l, 1'b0);
    chk({tag, "_done_l"}, done_l, exp_done);
  endtask

  task automatic load_word(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  // Called in the first SHIFT cycle; returns in the done cycle.
  // Stream bit 7 is the first bit expected on sout.
  task automatic check_stream(input string tag, input logic [7:0] ms, input logic [7:0] ls,
                              input int stall_at, input int stall_len);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("%s_b%0d_m", tag, i), sout_m, ms[7-i]);
      chk($sformatf("%s_b%0d_l", tag, i), sout_l, ls[7-i]);
      chk($sformatf("%s_b%0d_vld", tag, i), {sout_valid_m, sout_valid_l}, 2'b11);
      chk($sformatf("%s_b%0d_rdy", tag, i), {load_ready_m, load_ready_l}, 2'b00);
      chk($sformatf("%s_b%0d_done", tag, i), {done_m, done_l}, 2'b00);
      if (i == stall_at) begin
        shift_en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk($sformatf("%s_st%0d_m", tag, s), sout_m, ms[7-i]);
          chk($sformatf("%s_st%0d_l", tag, s), sout_l, ls[7-i]);
          chk($sformatf("%s_st%0d_vld", tag, s), {sout_valid_m, sout_valid_l}, 2'b11);
          chk($sformatf("%s_st%0d_done", tag, s), {done_m, done_l}, 2'b00);
        end
        shift_en = 1'b1;
      end
      tick();
    end
    chk_idle({tag, "_end"}, 1'b1);
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    shift_en   = 1'b1;

    // Reset values before any clock edge.
    #2;
    chk_idle("rst", 1'b0);

    // A load offered while reset is held must not be captured.
    load_valid = 1'b1;
    load_data  = 8'hA5;
    tick();
    chk_idle("rst_load", 1'b0);
    load_valid = 1'b0;
    reset      = 1'b1;
    tick();
    chk_idle("post_rst", 1'b0);

    // 0xC1 in both orders, shift_en held high.
    load_word(8'hC1);
    check_stream("c1", 8'b1100_0001, 8'b1000_0011, -1, 0);
    tick();
    chk_idle("c1_after", 1'b0);

    // 0xF0 with a 3-cycle stall after bit 2.
    load_word(8'hF0);
    check_stream("f0", 8'b1111_0000, 8'b0000_1111, 2, 3);
    tick();
    chk_idle("f0_after", 1'b0);

    // load_valid with 0x00 during SHIFT of 0xFF is ignored.
    load_word(8'hFF);
    load_valid = 1'b1;
    load_data  = 8'h00;
    check_stream("ff", 8'b1111_1111, 8'b1111_1111, -1, 0);
    load_valid = 1'b0;
    tick();
    chk_idle("ff_after", 1'b0);

    // Reset mid-word after 3 bits of 0xAA.
    load_word(8'hAA);
    chk("aa_b0", sout_m, 1'b1);
    tick();
    chk("aa_b1", sout_m, 1'b0);
    tick();
    chk("aa_b2", sout_m, 1'b1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk_idle("aa_rst", 1'b0);
    load_valid = 1'b1;
    load_data  = 8'h55;
    tick();
    chk_idle("aa_rst_hold", 1'b0);
    load_valid = 1'b0;
    reset      = 1'b1;
    tick();
    chk_idle("aa_rel", 1'b0);
    load_word(8'h81);
    check_stream("x81", 8'b1000_0001, 8'b1000_0001, -1, 0);
    tick();
    chk_idle("x81_after", 1'b0);

    // Back-to-back: second word accepted in the done cycle.
    load_word(8'h01);
    load_valid = 1'b1;
    load_data  = 8'h80;
    check_stream("bb1", 8'b0000_0001, 8'b1000_0000, -1, 0);
    tick();
    load_valid = 1'b0;
    check_stream("bb2", 8'b1000_0000, 8'b0000_0001, -1, 0);
    tick();
    chk_idle("bb_after", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
